// File: rtl/mio_bus_responder_pkg.sv
// Shared constants for the MEM-stage bus: ALU opcodes, MIO address regions,
// responder FSM encoding and the default IO register addresses.
package mio_bus_responder_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;

   typedef enum logic [1:0] {
      REG_RAM   = 2'd0,
      REG_GPIO  = 2'd1,
      REG_TIMER = 2'd2,
      REG_NONE  = 2'd3
   } region_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [31:0] DEF_GPIO_BASE  = 32'hF000_0000;
   localparam logic [31:0] DEF_TIMER_BASE = 32'hF000_0004;
   localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/mio_bus_responder_addr_decode.sv
// Combinational MIO address decoder: maps a byte address to its region.
// Word accesses only, so the two low address bits never affect the result.
module mio_addr_decode
   import mio_bus_responder_pkg::*;
#(
   parameter int          RAM_AW     = 10,
   parameter logic [31:0] GPIO_BASE  = DEF_GPIO_BASE,
   parameter logic [31:0] TIMER_BASE = DEF_TIMER_BASE
)
(
   input  logic [31:0] addr,
   output region_t     region
);

   logic [31:0] wordAddr_s;

   assign wordAddr_s = addr & WORD_MASK;

   // RAM window takes priority over the IO words
   always_comb begin
      region = REG_NONE;
      if ((addr >> (RAM_AW + 2)) == 32'd0) begin
         region = REG_RAM;
      end else if (wordAddr_s == (GPIO_BASE & WORD_MASK)) begin
         region = REG_GPIO;
      end else if (wordAddr_s == (TIMER_BASE & WORD_MASK)) begin
         region = REG_TIMER;
      end else begin
         region = REG_NONE;
      end
   end

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: completes MEM-stage loads/stores to data RAM, GPIO and
// the free-running timer, pulsing MIO_ready once per accepted request.
module mio_bus_responder
   import mio_bus_responder_pkg::*;
#(
   parameter int          RAM_AW      = 10,
   parameter int          RAM_LATENCY = 2,
   parameter logic [31:0] GPIO_BASE   = DEF_GPIO_BASE,
   parameter logic [31:0] TIMER_BASE  = DEF_TIMER_BASE
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic [31:0]       addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              MIO_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw,
   output logic [15:0]       led
);

   localparam logic [7:0] RAM_CNT_INIT = 8'(RAM_LATENCY - 1);

   logic [1:0]        state_r;
   logic [7:0]        cnt_r;
   logic [RAM_AW-1:0] ramAddr_r;
   logic [31:0]       latWdata_r;
   logic              latWrite_r;
   region_t           latRegion_r;
   region_t           region_s;
   logic              ramEn_r;
   logic              ramWe_r;
   logic              mioReady_r;
   logic [31:0]       cpuRdata_r;
   logic [15:0]       led_r;
   logic [31:0]       timer_r;
   logic [31:0]       timerNext_s;
   logic              complete_s;

   mio_addr_decode #(
      .RAM_AW     (RAM_AW),
      .GPIO_BASE  (GPIO_BASE),
      .TIMER_BASE (TIMER_BASE)
   ) uDecode (
      .addr   (addr),
      .region (region_s)
   );

   assign complete_s = (state_r == ST_WAIT) && (cnt_r == 8'd0);

   // Next timer value; a completing timer store overrides the increment
   always_comb begin
      timerNext_s = timer_r + 32'd1;
      if (complete_s && latWrite_r && (latRegion_r == REG_TIMER)) begin
         timerNext_s = latWdata_r;
      end else begin
         timerNext_s = timer_r + 32'd1;
      end
   end

   // Free-running timer register
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r <= 32'd0;
      end else begin
         timer_r <= timerNext_s;
      end
   end

   // Request FSM: accept in IDLE, count region latency in WAIT, turnaround in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         ramAddr_r   <= '0;
         latWdata_r  <= 32'd0;
         latWrite_r  <= 1'b0;
         latRegion_r <= REG_NONE;
         ramEn_r     <= 1'b0;
         ramWe_r     <= 1'b0;
         mioReady_r  <= 1'b0;
         cpuRdata_r  <= 32'd0;
         led_r       <= 16'd0;
      end else begin
         ramEn_r    <= 1'b0;
         ramWe_r    <= 1'b0;
         mioReady_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (mem_r || mem_w) begin
                  ramAddr_r   <= addr[RAM_AW+1:2];
                  latWdata_r  <= cpu_wdata;
                  latWrite_r  <= mem_w;
                  latRegion_r <= region_s;
                  state_r     <= ST_WAIT;
                  if (region_s == REG_RAM) begin
                     ramEn_r <= 1'b1;
                     ramWe_r <= mem_w;
                     cnt_r   <= RAM_CNT_INIT;
                  end else begin
                     cnt_r <= 8'd0;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_r != 8'd0) begin
                  cnt_r <= cnt_r - 8'd1;
               end else begin
                  mioReady_r <= 1'b1;
                  state_r    <= ST_DONE;
                  if (latWrite_r) begin
                     cpuRdata_r <= 32'd0;
                     if (latRegion_r == REG_GPIO) begin
                        led_r <= latWdata_r[15:0];
                     end
                  end else begin
                     case (latRegion_r)
                        REG_RAM:   cpuRdata_r <= ram_rdata;
                        REG_GPIO:  cpuRdata_r <= {16'd0, sw};
                        REG_TIMER: cpuRdata_r <= timerNext_s;
                        default:   cpuRdata_r <= 32'd0;
                     endcase
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata = cpuRdata_r;
   assign MIO_ready = mioReady_r;
   assign ram_en    = ramEn_r;
   assign ram_we    = ramWe_r;
   assign ram_addr  = ramAddr_r;
   assign ram_wdata = latWdata_r;
   assign led       = led_r;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed steps plus random
// accesses, checked against an address-map / cycle-count reference model.
module tb_mio_bus_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_r = 1'b0;
   logic        mem_w = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic [31:0] cpu_rdata;
   logic        MIO_ready;
   logic        ram_en;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'd0;
   logic [15:0] sw = 16'd0;
   logic [15:0] led;

   logic        ramInit = 1'b1;
   logic [31:0] memArr [1024];
   logic [31:0] refMem [1024];
   logic [15:0] ledModel;
   logic [31:0] tLoad;
   int unsigned tCyc;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   mio_bus_responder #(.RAM_AW(10), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .sw(sw), .led(led)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] seedWord(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   // Synchronous data RAM attached to the responder
   always @(posedge clk) begin
      if (ramInit) begin
         for (int i = 0; i < 1024; i++) memArr[i] <= seedWord(i);
      end else if (ram_en) begin
         if (ram_we) memArr[ram_addr] <= ram_wdata;
         else        ram_rdata <= memArr[ram_addr];
      end
   end

   // 0 = RAM, 1 = GPIO, 2 = timer, 3 = unmapped
   function automatic int regionOf(input logic [31:0] a);
      if (a < 32'h0000_1000) return 0;
      if ((a >> 2) == (32'hF000_0000 >> 2)) return 1;
      if ((a >> 2) == (32'hF000_0004 >> 2)) return 2;
      return 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic doAccess(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
      int          kind;
      int unsigned accCyc;
      int          enCnt;
      logic        weSeen;
      logic        seen;
      logic [31:0] expData;
      kind = regionOf(a);
      mem_r = rd; mem_w = wr; addr = a; cpu_wdata = wd;
      @(posedge clk); #1;
      accCyc = cyc;
      mem_r = 1'b0; mem_w = 1'b0; addr = $urandom; cpu_wdata = $urandom;
      enCnt = 0; weSeen = 1'b0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (ram_en) begin enCnt++; weSeen = ram_we; end
         if (MIO_ready) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, cyc - accCyc, (kind == 0) ? 32'(LAT) : 32'd1);
      chk({tag, "_ram_en_cycles"}, 32'(enCnt), (kind == 0) ? 32'd1 : 32'd0);
      if (kind == 0) chk({tag, "_ram_we"}, 32'(weSeen), 32'(wr));
      if (wr) begin
         expData = 32'd0;
         case (kind)
            0: refMem[a[11:2]] = wd;
            1: ledModel = wd[15:0];
            2: begin tLoad = wd; tCyc = cyc; end
            default: ;
         endcase
      end else begin
         case (kind)
            0: expData = refMem[a[11:2]];
            1: expData = {16'd0, sw};
            2: expData = tLoad + 32'(cyc - tCyc);
            default: expData = 32'd0;
         endcase
      end
      chk({tag, "_rdata"}, cpu_rdata, expData);
      @(posedge clk); #1;
      chk({tag, "_ready_pulse"}, 32'(MIO_ready), 32'd0);
      chk({tag, "_led"}, 32'(led), 32'(ledModel));
   endtask

   initial begin
      int unsigned readyQ [$];
      int unsigned dropAt;
      int          enCount;
      int          bad;
      logic [31:0] wd;
      logic [31:0] a;
      int          op;
      int          kind;

      for (int i = 0; i < 1024; i++) refMem[i] = seedWord(i);
      ledModel = 16'd0;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(MIO_ready), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      tLoad = 32'd0; tCyc = cyc;
      rst = 1'b0; ramInit = 1'b0;

      // RAM load of the preloaded word
      doAccess(1'b1, 1'b0, 32'h0000_0010, 32'd0, "ram_load");

      // GPIO store then load
      sw = 16'h1234;
      doAccess(1'b0, 1'b1, 32'hF000_0000, 32'h0000_A5A5, "gpio_store");
      doAccess(1'b1, 1'b0, 32'hF000_0000, 32'd0, "gpio_load");

      // Timer store near wrap, then immediate load
      doAccess(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, "timer_store");
      doAccess(1'b1, 1'b0, 32'hF000_0004, 32'd0, "timer_wrap_load");

      // Held request: one RAM read per acceptance, pulses spaced by the turnaround
      addr = 32'h0000_0020; mem_r = 1'b1; mem_w = 1'b0;
      dropAt = 32'hFFFF_FFFF; enCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ram_en) enCount++;
         if (MIO_ready) begin
            readyQ.push_back(cyc);
            chk("hold_rdata", cpu_rdata, refMem[8]);
            if (readyQ.size() == 1) dropAt = cyc + 3;
         end
         if (cyc == dropAt) mem_r = 1'b0;
      end
      chk("hold_ready_count", 32'(readyQ.size()), 32'd2);
      chk("hold_ram_reads", 32'(enCount), 32'd2);
      if (readyQ.size() == 2) chk("hold_spacing", readyQ[1] - readyQ[0], 32'(LAT + 2));

      // Simultaneous read+write is a store
      wd = $urandom;
      doAccess(1'b1, 1'b1, 32'h0000_0008, wd, "rw_both");
      doAccess(1'b1, 1'b0, 32'h0000_0008, 32'd0, "rw_both_readback");

      // Unmapped store/load
      doAccess(1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, "unmapped_store");
      doAccess(1'b1, 1'b0, 32'h8000_0000, 32'd0, "unmapped_load");

      // Reset while a RAM store is in WAIT
      wd = $urandom;
      mem_w = 1'b1; addr = 32'h0000_0040; cpu_wdata = wd;
      @(posedge clk); #1;
      mem_w = 1'b0;
      chk("abort_ram_en", 32'(ram_en), 32'd1);
      @(posedge clk); #1;
      refMem[16] = wd;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tLoad = 32'd0; tCyc = cyc; ledModel = 16'd0;
      chk("abort_led", 32'(led), 32'd0);
      chk("abort_ram_en_after", 32'(ram_en), 32'd0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (MIO_ready || ram_en) bad++;
         @(posedge clk); #1;
      end
      chk("abort_no_ready", 32'(bad), 32'd0);
      doAccess(1'b1, 1'b0, 32'hF000_0004, 32'd0, "abort_timer_load");
      doAccess(1'b1, 1'b0, 32'h0000_0040, 32'd0, "abort_ram_load");

      // Random accesses
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         a = $urandom;
         case (kind)
            0: a = {20'd0, a[11:0]};
            1: a = 32'hF000_0000 | {30'd0, a[1:0]};
            2: a = 32'hF000_0004 | {30'd0, a[1:0]};
            default: if (regionOf(a) != 3) a = 32'h8000_0000 | {30'd0, a[1:0]};
         endcase
         op = $urandom_range(1, 3);
         sw = 16'($urandom);
         doAccess(1'(op & 1), 1'((op >> 1) & 1), a, $urandom, "random");
      end

      bad = 0;
      for (int i = 0; i < 1024; i++) if (memArr[i] !== refMem[i]) bad++;
      chk("ram_contents", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO responder on the CPU's MIO bus. The MEM-stage load/store logic issues requests; this block completes them and drives MIO_ready back to the pipeline control, which stalls until ready.
- Decodes the address into data RAM, switch/LED GPIO, a free-running timer, or unmapped space.
- Each region has its own access latency, sequenced by a small FSM.

Parameters:
- RAM_AW, 10, RAM word-address width (4 KiB window at 0x0000_0000).
- RAM_LATENCY, 2, cycles from request acceptance to MIO_ready for RAM accesses. Must be ≥1.
- GPIO_BASE, 32'hF000_0000, switch-read / LED-write register.
- TIMER_BASE, 32'hF000_0004, timer register.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_r  in  1  load request from MEM stage
- mem_w  in  1  store request from MEM stage
- addr  in  32  byte address; bits [1:0] ignored (word access only)
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while MIO_ready=1
- MIO_ready  out  1  one-cycle completion pulse
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  RAM word address (addr[RAM_AW+1:2])
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid from the cycle after ram_en and held
- sw  in  16  board switches
- led  out  16  LED register

Behaviour:
- Reset: state=IDLE; MIO_ready, ram_en, ram_we = 0; cpu_rdata=0; led=0; timer=0; latency counter=0. Reset mid-transaction aborts it; no MIO_ready is issued and no RAM or LED write occurs after the reset edge.
- States: IDLE, WAIT, DONE.
- IDLE:
  - At a clock edge with mem_r|mem_w=1, latch addr, cpu_wdata, op and region.
  - If mem_r and mem_w are both high, the access is a store.
  - RAM region: ram_en=1 (ram_we=op) for exactly the one cycle after acceptance; counter=RAM_LATENCY-1; go to WAIT.
  - Any other region: go to WAIT with counter=0.
- WAIT:
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the register side-effect, present cpu_rdata, pulse MIO_ready=1, go to DONE.
  - RAM latency: MIO_ready is high exactly RAM_LATENCY cycles after the acceptance edge.
  - IO/unmapped latency: MIO_ready is high 1 cycle after the acceptance edge.
- DONE: requests are ignored for one cycle (turnaround), MIO_ready=0, then go to IDLE. The CPU must drop or replace its request on the edge at which it samples MIO_ready=1; the turnaround prevents double acceptance of a held request.
- Request signals are not re-sampled in WAIT. Deasserting mem_r/mem_w mid-transaction does not cancel it: it still completes and pulses MIO_ready.
- Region decode on latched addr:
  - addr[31:RAM_AW+2]==0 → RAM.
  - Word-equal GPIO_BASE → GPIO: read returns {16'b0, sw}; write sets led=cpu_wdata[15:0].
  - Word-equal TIMER_BASE → timer: read returns the timer value; write loads the timer.
  - Otherwise unmapped: read returns 0, write is discarded.
- Timer:
  - 32-bit; increments by 1 every cycle; wraps 0xFFFF_FFFF→0.
  - A store loads cpu_wdata in the MIO_ready cycle; it then increments from that value next cycle, so the store overrides the increment in that cycle.
  - A load returns the value during the MIO_ready cycle.
- cpu_rdata: updated only in the MIO_ready cycle. Stores return 0. Otherwise it holds its value.
- ram_addr and ram_wdata are driven from the latched request. They may hold stale values while ram_en=0.
- Stores update RAM/LED/timer at most once per accepted request.

Decomposition:
- Shared package (with existing ALU/opcode constants):
  - region enum (REG_RAM, REG_GPIO, REG_TIMER, REG_NONE)
  - FSM state encoding
  - default GPIO_BASE/TIMER_BASE constants
- Sub-module mio_addr_decode: combinational addr→region. The FSM, timer and LED register stay in the top.

Test Plan:
- Reset, then load at 0x0000_0010 with RAM word 4 preloaded 0xDEAD_BEEF, RAM_LATENCY=2 → ram_en high 1 cycle; MIO_ready high exactly 2 cycles after acceptance with cpu_rdata=0xDEAD_BEEF; then one DONE cycle.
- Store 0x0000_A5A5 to 0xF000_0000, then load 0xF000_0000 with sw=0x1234 → led=0xA5A5 after the first MIO_ready; load returns 0x0000_1234; each MIO_ready is 1 cycle after acceptance.
- Store 0xFFFF_FFFE to 0xF000_0004, then load it immediately after DONE → the loaded value equals 0xFFFF_FFFE plus the elapsed cycles; the value wraps through 0 correctly.
- CPU holds mem_r high for 3 cycles past MIO_ready → exactly one RAM read per accepted request, with a 1-cycle DONE gap between MIO_ready pulses.
- mem_r and mem_w both high to RAM addr 0x8 → treated as a store (ram_we=1) and cpu_rdata=0. Store to unmapped 0x8000_0000 → MIO_ready after 1 cycle, no RAM/LED change; load from it returns 0.
- rst asserted in WAIT during a RAM store → no MIO_ready; state IDLE; led=0; timer=0; next request served normally.
